// File: rtl/processor_if.sv
// Observation bus of the single-cycle processor: the combinational ALU result
// of the instruction currently addressed by the PC.
interface processor_if;
  logic [31:0] Result;

  modport master (output Result);
  modport slave  (input  Result);
endinterface

// File: rtl/processor.sv
// Single-cycle RV32-style datapath: ROM fetch, decode, register file, ALU and
// data RAM all resolve within one clock; PC, registers and RAM update on the edge.
module processor (
  input  logic        clk,
  input  logic        reset,
  processor_if.master bus
);

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_NOR
  } alu_op_e;

  logic [31:0] pc_q = '0;
  logic [31:0] pc_d;
  logic [31:0] rf_q  [32];
  logic [31:0] ram_q [64] = '{default: 32'd0};

  logic [31:0] inst;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm, rs1_val, rs2_val, alu_b, alu_y, wb_data;
  logic        op_ok, reg_write, mem_write, mem_to_reg, use_imm;
  alu_op_e     alu_op;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3,
                                        input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d,
                                        input logic [6:0] op);
    return {im, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] s2,
                                        input logic [4:0] s1);
    return {im[11:5], s2, s1, 3'b010, im[4:0], 7'b0100011};
  endfunction

  // Program ROM; PC wraps every 256 bytes because only PC[7:2] indexes it.
  always_comb begin
    inst = '0;
    case (pc_q[7:2])
      6'd0:  inst = enc_r(7'h00, 5'd0,  5'd0,  3'b111, 5'd1);
      6'd1:  inst = enc_i(12'd1,   5'd0,  3'b000, 5'd1,  7'b0010011);
      6'd2:  inst = enc_i(12'd2,   5'd0,  3'b000, 5'd2,  7'b0010011);
      6'd3:  inst = enc_i(12'd3,   5'd1,  3'b000, 5'd3,  7'b0010011);
      6'd4:  inst = enc_i(12'd4,   5'd1,  3'b000, 5'd4,  7'b0010011);
      6'd5:  inst = enc_i(12'd5,   5'd2,  3'b000, 5'd5,  7'b0010011);
      6'd6:  inst = enc_i(12'd6,   5'd2,  3'b000, 5'd6,  7'b0010011);
      6'd7:  inst = enc_i(12'd7,   5'd3,  3'b000, 5'd7,  7'b0010011);
      6'd8:  inst = enc_r(7'h00, 5'd2,  5'd1,  3'b000, 5'd8);
      6'd9:  inst = enc_r(7'h20, 5'd8,  5'd1,  3'b000, 5'd9);
      6'd10: inst = enc_r(7'h00, 5'd4,  5'd2,  3'b111, 5'd10);
      6'd11: inst = enc_r(7'h00, 5'd3,  5'd1,  3'b110, 5'd11);
      6'd12: inst = enc_r(7'h00, 5'd1,  5'd9,  3'b010, 5'd12);
      6'd13: inst = enc_r(7'h00, 5'd7,  5'd6,  3'b100, 5'd13);
      6'd14: inst = enc_i(12'h4D3, 5'd9,  3'b111, 5'd14, 7'b0010011);
      6'd15: inst = enc_i(12'h8D2, 5'd4,  3'b110, 5'd15, 7'b0010011);
      6'd16: inst = enc_r(7'h00, 5'd1,  5'd15, 3'b010, 5'd16);
      6'd17: inst = enc_i(12'h4D3, 5'd14, 3'b100, 5'd17, 7'b0010011);
      6'd18: inst = enc_s(12'd48, 5'd8, 5'd0);
      6'd19: inst = enc_i(12'd48,  5'd0,  3'b010, 5'd19, 7'b0000011);
      default: inst = '0;
    endcase
  end

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  // R-type and I-type share the funct3 map; funct3 000 is add/sub vs addi.
  always_comb begin
    op_ok      = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    use_imm    = 1'b0;
    alu_op     = ALU_ADD;
    imm        = {{20{inst[31]}}, inst[31:20]};
    case (opcode)
      7'b0110011, 7'b0010011: begin
        use_imm = (opcode == 7'b0010011);
        op_ok   = 1'b1;
        case (funct3)
          3'b000: begin
            if (use_imm || funct7 == 7'b0000000) alu_op = ALU_ADD;
            else if (funct7 == 7'b0100000)       alu_op = ALU_SUB;
            else                                 op_ok  = 1'b0;
          end
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          3'b010:  alu_op = ALU_SLT;
          3'b100:  alu_op = ALU_NOR;
          default: op_ok  = 1'b0;
        endcase
        reg_write = op_ok;
      end
      7'b0000011: begin
        if (funct3 == 3'b010) begin
          op_ok      = 1'b1;
          use_imm    = 1'b1;
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
      end
      7'b0100011: begin
        if (funct3 == 3'b010) begin
          op_ok     = 1'b1;
          use_imm   = 1'b1;
          mem_write = 1'b1;
          imm       = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        end
      end
      default: ;
    endcase
  end

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
  assign alu_b   = use_imm ? imm : rs2_val;

  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD: alu_y = rs1_val + alu_b;
      ALU_SUB: alu_y = rs1_val - alu_b;
      ALU_AND: alu_y = rs1_val & alu_b;
      ALU_OR:  alu_y = rs1_val | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      ALU_NOR: alu_y = ~(rs1_val | alu_b);
      default: alu_y = '0;
    endcase
  end

  assign bus.Result = op_ok ? alu_y : 32'd0;
  assign wb_data    = mem_to_reg ? ram_q[alu_y[7:2]] : alu_y;
  assign pc_d       = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  always_ff @(posedge clk) begin
    if (!reset && reg_write && rd != 5'd0) rf_q[rd] <= wb_data;
  end

  always_ff @(posedge clk) begin
    if (!reset && mem_write) ram_q[alu_y[7:2]] <= rs2_val;
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_q[31:8], pc_q[1:0]};

endmodule

// File: tb/tb_processor.sv
// Scoreboard bench for processor: an instruction-level reference model predicts
// Result and architectural state each cycle under directed and random resets.
module tb_processor;

  localparam int OP_NOP = 0, OP_ADD = 1, OP_SUB = 2, OP_AND = 3, OP_OR = 4,
                 OP_SLT = 5, OP_NOR = 6, OP_ADDI = 7, OP_ANDI = 8, OP_ORI = 9,
                 OP_NORI = 10, OP_LW = 11, OP_SW = 12;

  logic clk = 1'b0;
  logic reset;
  processor_if pif ();

  processor dut (.clk(clk), .reset(reset), .bus(pif));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          ridx;
    bit          rchk;
    logic [31:0] rval;
    int          midx;
    logic [31:0] mval;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;

  int          m_op [64];
  int          m_rd [64];
  int          m_rs1[64];
  int          m_rs2[64];
  logic [31:0] m_imm[64];
  logic [31:0] m_reg[32];
  bit          m_known[32];
  logic [31:0] m_mem[64];
  logic [31:0] m_pc;

  task automatic prog(int w, int op, int d, int s1, int s2, logic [31:0] im);
    m_op[w] = op; m_rd[w] = d; m_rs1[w] = s1; m_rs2[w] = s2; m_imm[w] = im;
  endtask

  function automatic logic [31:0] rv(int r);
    return (r == 0) ? 32'd0 : m_reg[r];
  endfunction

  function automatic logic [31:0] m_eval(int w);
    logic [31:0] a, b;
    a = rv(m_rs1[w]);
    b = (m_op[w] >= OP_ADDI) ? m_imm[w] : rv(m_rs2[w]);
    case (m_op[w])
      OP_ADD, OP_ADDI, OP_LW, OP_SW: return a + b;
      OP_SUB:           return a - b;
      OP_AND, OP_ANDI:  return a & b;
      OP_OR, OP_ORI:    return a | b;
      OP_SLT:           return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_NOR, OP_NORI:  return ~(a | b);
      default:          return 32'd0;
    endcase
  endfunction

  task automatic m_step(bit rst);
    int w;
    logic [31:0] y;
    if (rst) begin
      m_pc = 32'd0;
      return;
    end
    w = int'(m_pc[7:2]);
    y = m_eval(w);
    if (m_op[w] == OP_SW) m_mem[y[7:2]] = rv(m_rs2[w]);
    else if (m_op[w] != OP_NOP && m_rd[w] != 0) begin
      m_reg[m_rd[w]]   = (m_op[w] == OP_LW) ? m_mem[y[7:2]] : y;
      m_known[m_rd[w]] = 1'b1;
    end
    m_pc = m_pc + 32'd4;
  endtask

  // One cycle of stimulus: predict the current cycle, then advance the model over the next edge.
  task automatic cycle(bit r);
    exp_t e;
    reset  = r;
    e.res  = m_eval(int'(m_pc[7:2]));
    e.ridx = ($urandom_range(0, 1) == 1) ? 19 : int'($urandom_range(1, 31));
    e.rchk = m_known[e.ridx];
    e.rval = m_reg[e.ridx];
    e.midx = ($urandom_range(0, 1) == 1) ? 12 : int'($urandom_range(0, 63));
    e.mval = m_mem[e.midx];
    e.cyc  = cyc;
    sb.push_back(e);
    m_step(r);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      prog(i, OP_NOP, 0, 0, 0, 32'd0);
      m_mem[i] = 32'd0;
    end
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = 32'd0;
      m_known[i] = 1'b0;
    end
    m_pc = 32'd0;
    prog(0,  OP_AND,  1,  0,  0, 32'd0);
    prog(1,  OP_ADDI, 1,  0,  0, 32'd1);
    prog(2,  OP_ADDI, 2,  0,  0, 32'd2);
    prog(3,  OP_ADDI, 3,  1,  0, 32'd3);
    prog(4,  OP_ADDI, 4,  1,  0, 32'd4);
    prog(5,  OP_ADDI, 5,  2,  0, 32'd5);
    prog(6,  OP_ADDI, 6,  2,  0, 32'd6);
    prog(7,  OP_ADDI, 7,  3,  0, 32'd7);
    prog(8,  OP_ADD,  8,  1,  2, 32'd0);
    prog(9,  OP_SUB,  9,  1,  8, 32'd0);
    prog(10, OP_AND,  10, 2,  4, 32'd0);
    prog(11, OP_OR,   11, 1,  3, 32'd0);
    prog(12, OP_SLT,  12, 9,  1, 32'd0);
    prog(13, OP_NOR,  13, 6,  7, 32'd0);
    prog(14, OP_ANDI, 14, 9,  0, 32'h0000_04D3);
    prog(15, OP_ORI,  15, 4,  0, 32'hFFFF_F8D2);
    prog(16, OP_SLT,  16, 15, 1, 32'd0);
    prog(17, OP_NORI, 17, 14, 0, 32'h0000_04D3);
    prog(18, OP_SW,   0,  0,  8, 32'd48);
    prog(19, OP_LW,   19, 0,  0, 32'd48);

    cycle(1'b1);
    for (int i = 0; i < 30; i++) cycle(1'b0);
    cycle(1'b1);
    for (int i = 0; i < 64 && m_pc != 32'h20; i++) cycle(1'b0);
    cycle(1'b1);
    for (int i = 0; i < 25; i++) cycle(1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1);
    for (int i = 0; i < 70; i++) cycle(1'b0);
    for (int i = 0; i < 300; i++) cycle($urandom_range(0, 15) == 0);

    #30;
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Monitor: samples 2 time units after each stimulus step, mid-cycle.
  initial begin
    exp_t e;
    logic [31:0] act;
    #2;
    forever begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (pif.Result === e.res) passes++;
        else $display("FAIL result cyc=%0d got=%h exp=%h", e.cyc, pif.Result, e.res);
        if (e.rchk) begin
          act = dut.rf_q[e.ridx];
          checks++;
          if (act === e.rval) passes++;
          else $display("FAIL reg x%0d cyc=%0d got=%h exp=%h", e.ridx, e.cyc, act, e.rval);
        end
        act = dut.ram_q[e.midx];
        checks++;
        if (act === e.mval) passes++;
        else $display("FAIL ram[%0d] cyc=%0d got=%h exp=%h", e.midx, e.cyc, act, e.mval);
      end
      #10;
    end
  end

endmodule

// File: doc/processor.md
# processor

Single-cycle 32-bit RISC-V-style processor with internal instruction ROM, register file, ALU and data memory. Every instruction fetches, decodes, executes, accesses memory and writes back within one clock cycle. The only observable output is the ALU result of the instruction currently addressed by the PC. It is the top-level block of the lab datapath.

## Interface
- No parameters.
- clk  input  1  rising-edge clock for PC, register file and data memory.
- reset  input  1  synchronous, active-high; forces PC to 0 on the next rising edge.
- Result  output  32  combinational ALU result of the current instruction. For lw and sw this is the effective address.

## Operation
- Architectural state:
  - PC: 32 bits, byte address, initialised to 0 at time zero.
  - Register file: 32×32, x0 hardwired to 0.
  - Instruction ROM: 64 words, indexed by PC[7:2].
  - Data RAM: 64 words, indexed by address[7:2], initialised to 0.
- Supported instructions (RV32 encodings):
  - R-type, opcode 0110011:
    - add: funct3 000, funct7 0000000
    - sub: funct3 000, funct7 0100000
    - and: funct3 111
    - or: funct3 110
    - slt (signed): funct3 010
    - nor: funct3 100; this replaces xor.
  - I-type, opcode 0010011: addi 000, andi 111, ori 110, slti 010, nori 100.
  - lw: opcode 0000011, funct3 010.
  - sw: opcode 0100011, funct3 010.
- Immediates:
  - I-type: the 12-bit immediate is sign-extended.
  - sw: imm = {inst[31:25], inst[11:7]}, sign-extended.
- ALU:
  - add/sub are modulo 2^32.
  - slt returns 1 if signed A < B, else 0.
  - nor returns ~(A|B).
  - Logical immediates use the sign-extended immediate.
- Register and memory access:
  - Register reads are combinational.
  - Write-back is ALU result, or RAM read data for lw. It is written at the rising edge when RegWrite=1 and reset=0.
  - Writes to x0 are discarded.
  - sw writes rs2 to RAM at the rising edge when reset=0.
  - lw read is combinational.
- Any other opcode, including the all-zero word, is a NOP:
  - no register write, no memory write;
  - Result = 0.
- ROM contents (word index: instruction → Result). ROM words 20–63 are 0 (NOP).
  - 0: and x1,x0,x0 → 0
  - 1: addi x1,x0,1 → 1
  - 2: addi x2,x0,2 → 2
  - 3: addi x3,x1,3 → 4
  - 4: addi x4,x1,4 → 5
  - 5: addi x5,x2,5 → 7
  - 6: addi x6,x2,6 → 8
  - 7: addi x7,x3,7 → 0xB
  - 8: add x8,x1,x2 → 3
  - 9: sub x9,x1,x8 → 0xFFFFFFFE
  - 10: and x10,x2,x4 → 0
  - 11: or x11,x1,x3 → 5
  - 12: slt x12,x9,x1 → 1
  - 13: nor x13,x6,x7 → 0xFFFFFFF4
  - 14: andi x14,x9,0x4D3 → 0x4D2
  - 15: ori x15,x4,0x8D2 → 0xFFFFF8D7
  - 16: slt x16,x15,x1 → 1
  - 17: nori x17,x14,0x4D3 → 0xFFFFFB2C
  - 18: sw x8,48(x0) → 0x30
  - 19: lw x19,48(x0) → 0x30

## Timing
- At every rising edge:
  - reset=1: PC←0; register and memory writes are suppressed.
  - reset=0: PC←PC+4.
- Result is valid combinationally within the same cycle the PC holds the instruction. Latency is 0 cycles from PC to Result; one instruction retires per cycle.
- During reset, and at time zero before any edge, PC=0, so Result shows instruction 0 (value 0).
- Reset asserted mid-program:
  - The edge that samples reset=1 loads PC=0 and suppresses that cycle's write.
  - Execution restarts at instruction 0.
  - Registers and RAM keep their prior contents; they are not cleared.
- PC wraps modulo 256 bytes via ROM indexing. After instruction 19, Result stays 0 until wrap.
- A read of a register written in the previous cycle sees the new value. No same-cycle bypass is needed.

## Test plan
- Assert reset for one edge, then release → Result is 0 during reset. It then steps through 1, 2, 4, 5, 7, 8, 0xB, 3, 0xFFFFFFFE, 0, 5, 1, 0xFFFFFFF4, 0x4D2, 0xFFFFF8D7, 1, 0xFFFFFB2C, 0x30, 0x30 on successive rising edges; check each value mid-cycle.
- After instruction 18 retires → RAM word 12 = 3. After instruction 19 → x19 = 3.
- Instruction 0 writes x1 = 0, and instruction 1 then writes 1 → x1 = 1. x0 reads 0 throughout.
- Cycle 21 onward (NOP region) → Result = 0, and no register or RAM changes.
- Assert reset while PC=0x20 → next edge PC=0 and Result=0, with no write-back in that cycle. After release, the sequence replays identically.
- Hold reset high for 5 edges → PC stays 0, Result stays 0, no state changes.
